// File: rtl/pipe_valid_ctrl.sv
// Valid/allowin control for the 5-stage IF/ID/EX/MEM/WB pipeline.
// It derives the backpressure chain, the pipeline-register load enables and the fetch request gate.
// It counts outstanding fetches so that responses from a flushed path are dropped.
module pipe_valid_ctrl #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req_ready,
    output logic inst_req_valid,
    input  logic inst_resp_valid,
    input  logic id_write_en,
    input  logic ex_ready_go,
    input  logic mem_ready_go,
    input  logic if_flush,
    input  logic id_flush,
    input  logic ex_flush,
    input  logic mem_flush,
    output logic if_valid,
    output logic id_valid,
    output logic ex_valid,
    output logic mem_valid,
    output logic wb_valid,
    output logic if_load,
    output logic id_load,
    output logic ex_load,
    output logic mem_load,
    output logic wb_load,
    output logic resp_discard
);

    localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic if_valid_q, id_valid_q, ex_valid_q, mem_valid_q, wb_valid_q;
    logic if_valid_d, id_valid_d, ex_valid_d, mem_valid_d, wb_valid_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic if_allowin, id_allowin, ex_allowin, mem_allowin;
    logic if_to_next, id_to_next, ex_to_next, mem_to_next;
    logic req_accept;

    // Backpressure ripples from WB (always accepting) back toward IF; flushes stay out of this path.
    assign mem_allowin = !mem_valid_q || mem_ready_go;
    assign ex_allowin  = !ex_valid_q  || (ex_ready_go && mem_allowin);
    assign id_allowin  = !id_valid_q  || (id_write_en && ex_allowin);
    assign if_allowin  = !if_valid_q  || id_allowin;

    // An ID stall hands nothing to EX, so EX takes in a bubble.
    assign if_to_next  = if_valid_q;
    assign id_to_next  = id_valid_q  && id_write_en;
    assign ex_to_next  = ex_valid_q  && ex_ready_go;
    assign mem_to_next = mem_valid_q && mem_ready_go;

    // A stage's own flush kills its incoming load; the upstream flush never gates it.
    assign id_load  = id_allowin  && if_to_next && !id_flush;
    assign ex_load  = ex_allowin  && id_to_next && !ex_flush;
    assign mem_load = mem_allowin && ex_to_next && !mem_flush;
    assign wb_load  = mem_to_next;

    assign resp_discard   = inst_resp_valid && (discard_q != '0);
    assign if_load        = inst_resp_valid && !resp_discard && if_allowin && !if_flush;
    assign inst_req_valid = (outstanding_q < MAX_CNT) && if_allowin && !if_flush && resetn;
    assign req_accept     = inst_req_valid && inst_req_ready;

    assign if_valid  = if_valid_q;
    assign id_valid  = id_valid_q;
    assign ex_valid  = ex_valid_q;
    assign mem_valid = mem_valid_q;
    assign wb_valid  = wb_valid_q;

    // Next-state: the flush wins, then an allowed stage takes its upstream handoff, otherwise it holds.
    always_comb begin
        if_valid_d = if_valid_q;
        if (if_flush)                       if_valid_d = 1'b0;
        else if (if_load)                   if_valid_d = 1'b1;
        else if (if_to_next && id_allowin)  if_valid_d = 1'b0;

        id_valid_d = id_valid_q;
        if (id_flush)        id_valid_d = 1'b0;
        else if (id_allowin) id_valid_d = if_to_next;

        ex_valid_d = ex_valid_q;
        if (ex_flush)        ex_valid_d = 1'b0;
        else if (ex_allowin) ex_valid_d = id_to_next;

        mem_valid_d = mem_valid_q;
        if (mem_flush)        mem_valid_d = 1'b0;
        else if (mem_allowin) mem_valid_d = ex_to_next;

        wb_valid_d = mem_to_next;

        // An accept and a response in the same cycle cancel each other out. The zero guard protects the counter from a stray response.
        outstanding_d = outstanding_q;
        if (req_accept && !inst_resp_valid)
            outstanding_d = outstanding_q + CW'(1);
        else if (!req_accept && inst_resp_valid && outstanding_q != '0)
            outstanding_d = outstanding_q - CW'(1);

        // A flush reloads the discard count rather than adding to it. The request gate is closed during a flush, so there is no accept to count.
        discard_d = discard_q;
        if (if_flush)
            discard_d = outstanding_q - CW'(inst_resp_valid);
        else if (resp_discard)
            discard_d = discard_q - CW'(1);
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            if_valid_q    <= 1'b0;
            id_valid_q    <= 1'b0;
            ex_valid_q    <= 1'b0;
            mem_valid_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            if_valid_q    <= if_valid_d;
            id_valid_q    <= id_valid_d;
            ex_valid_q    <= ex_valid_d;
            mem_valid_q   <= mem_valid_d;
            wb_valid_q    <= wb_valid_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Every response must match an earlier accepted request.
    resp_has_req: assert property (@(posedge clk) disable iff (!resetn)
        inst_resp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_pipe_valid_ctrl.sv
// Directed bench for pipe_valid_ctrl.
// It drives one row per cycle and checks the valid bits, the load enables, the request gate and the discard flag.
module tb_pipe_valid_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic inst_req_ready = 1'b1;
    logic inst_req_valid;
    logic inst_resp_valid = 1'b0;
    logic id_write_en = 1'b1, ex_ready_go = 1'b1, mem_ready_go = 1'b1;
    logic if_flush = 1'b0, id_flush = 1'b0, ex_flush = 1'b0, mem_flush = 1'b0;
    logic if_valid, id_valid, ex_valid, mem_valid, wb_valid;
    logic if_load, id_load, ex_load, mem_load, wb_load;
    logic resp_discard;

    int checks = 0;
    int failures = 0;
    int mem_pend = 0;
    int cyc_n = 0;

    pipe_valid_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req_ready(inst_req_ready), .inst_req_valid(inst_req_valid),
        .inst_resp_valid(inst_resp_valid),
        .id_write_en(id_write_en), .ex_ready_go(ex_ready_go), .mem_ready_go(mem_ready_go),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .if_valid(if_valid), .id_valid(id_valid), .ex_valid(ex_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid),
        .if_load(if_load), .id_load(id_load), .ex_load(ex_load),
        .mem_load(mem_load), .wb_load(wb_load),
        .resp_discard(resp_discard)
    );

    always #5 clk = ~clk;

    wire [4:0] vld = {if_valid, id_valid, ex_valid, mem_valid, wb_valid};
    wire [4:0] lds = {if_load, id_load, ex_load, mem_load, wb_load};

    // Instruction memory model: it tracks accepted requests and returns them in order when the row allows it.
    always @(posedge clk) begin
        if (!resetn) mem_pend <= 0;
        else mem_pend <= mem_pend + int'(inst_req_valid && inst_req_ready) - int'(inst_resp_valid);
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc_n, got, exp);
        end
    endtask

    // fl = {if,id,ex,mem} flush; ctl = {id_write_en, ex_ready_go, mem_ready_go, resp_en}
    task automatic cyc(input logic [3:0] fl, input logic [3:0] ctl,
                       input logic [4:0] ev, input logic [4:0] el,
                       input logic er, input logic ed);
        @(negedge clk);
        cyc_n++;
        resetn = 1'b1;
        {if_flush, id_flush, ex_flush, mem_flush} = fl;
        {id_write_en, ex_ready_go, mem_ready_go} = ctl[3:1];
        inst_resp_valid = ctl[0] && (mem_pend > 0);
        #1;
        chk("valid", {3'b0, vld}, {3'b0, ev});
        chk("load", {3'b0, lds}, {3'b0, el});
        chk("req", {7'b0, inst_req_valid}, {7'b0, er});
        chk("discard", {7'b0, resp_discard}, {7'b0, ed});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {3'b0, vld}, 8'd0);
        chk("rst_load", {3'b0, lds}, 8'd0);
        chk("rst_req", {7'b0, inst_req_valid}, 8'd0);
        // fill: the request rises on the first cycle, the first response arrives in c2, and WB becomes valid in c7
        cyc(4'b0000, 4'b1111, 5'b00000, 5'b00000, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b00000, 5'b10000, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b10000, 5'b11000, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11000, 5'b11100, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11100, 5'b11110, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11110, 5'b11111, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11111, 5'b11111, 1'b1, 1'b0);
        // ID stalls for 2 cycles: bubbles go into EX and IF is held
        cyc(4'b0000, 4'b0110, 5'b11111, 5'b00011, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0110, 5'b11011, 5'b00001, 1'b0, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11001, 5'b11100, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11100, 5'b11110, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11110, 5'b11111, 1'b1, 1'b0);
        // EX is busy for 3 cycles: IF/ID/EX hold, MEM drains and no request goes out
        cyc(4'b0000, 4'b1010, 5'b11111, 5'b00001, 1'b0, 1'b0);
        cyc(4'b0000, 4'b1010, 5'b11101, 5'b00000, 1'b0, 1'b0);
        cyc(4'b0000, 4'b1010, 5'b11100, 5'b00000, 1'b0, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11100, 5'b11110, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11110, 5'b11111, 1'b1, 1'b0);
        // a held-back response brings outstanding to 2; flush IF/ID/EX; two responses are dropped and the third loads
        cyc(4'b0000, 4'b1110, 5'b11111, 5'b01111, 1'b1, 1'b0);
        cyc(4'b1110, 4'b1110, 5'b01111, 5'b00011, 1'b0, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b00011, 5'b00001, 1'b0, 1'b1);
        cyc(4'b0000, 4'b1111, 5'b00001, 5'b00000, 1'b1, 1'b1);
        cyc(4'b0000, 4'b1111, 5'b00000, 5'b10000, 1'b1, 1'b0);
        // a flush that coincides with a response: that response is not loaded and exactly one more is dropped
        cyc(4'b0000, 4'b1110, 5'b10000, 5'b01000, 1'b1, 1'b0);
        cyc(4'b1000, 4'b1111, 5'b01000, 5'b00100, 1'b0, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b00100, 5'b00010, 1'b1, 1'b1);
        cyc(4'b0000, 4'b1111, 5'b00010, 5'b10001, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b10001, 5'b11000, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11000, 5'b11100, 1'b1, 1'b0);
        // a MEM flush in the same cycle as an EX load: EX loads and MEM clears
        cyc(4'b0001, 4'b1111, 5'b11100, 5'b11100, 1'b1, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11100, 5'b11110, 1'b1, 1'b0);
        // one MEM wait cycle: the whole front holds
        cyc(4'b0000, 4'b1100, 5'b11110, 5'b00000, 1'b0, 1'b0);
        cyc(4'b0000, 4'b1111, 5'b11110, 5'b11111, 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_valid_ctrl.md
Name: pipe_valid_ctrl

Overview:
- Per-stage valid/allowin control for the 5-stage LoongArch pipeline (IF, ID, EX, MEM, WB).
- Takes the stall and flush requests produced by hazard detection (ID write-enable, stage flushes) and stage ready_go signals.
- Produces stage valid bits, pipeline-register load enables and the instruction-fetch request gate.
- Tracks outstanding instruction-fetch requests, so that responses belonging to a flushed path are discarded after a flush.

Parameters:
- MAX_OUTSTANDING, 2, maximum instruction-fetch requests in flight; the outstanding counter and discard counter are $clog2(MAX_OUTSTANDING+1) bits wide.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- inst_req_ready  in  1  instruction memory accepts a request
- inst_req_valid  out  1  fetch request issued
- inst_resp_valid  in  1  fetch data returned (one per accepted request, in order)
- id_write_en  in  1  ID ready_go from hazard detection (0 = ID held, bubble into EX)
- ex_ready_go  in  1  EX done (0 during multi-cycle divide)
- mem_ready_go  in  1  MEM done (0 while data access pending)
- if_flush, id_flush, ex_flush, mem_flush  in  1 each  clear the valid bit of that stage
- if_valid, id_valid, ex_valid, mem_valid, wb_valid  out  1 each  stage valid bits
- id_load, ex_load, mem_load, wb_load  out  1 each  load enables of the IF/ID, ID/EX, EX/MEM, MEM/WB registers
- if_load  out  1  capture the accepted fetch response into the IF register
- resp_discard  out  1  current inst_resp_valid is dropped

Behaviour:
- Reset (asynchronous, resetn=0):
  - All *_valid = 0.
  - outstanding = 0 and discard = 0.
  - inst_req_valid = 0.
  - All load enables = 0.
- ready_go per stage:
  - IF = 1; ID = id_write_en; EX = ex_ready_go; MEM = mem_ready_go; WB = 1.
- allowin:
  - wb_allowin = 1.
  - For every other stage s: allowin_s = !valid_s || (ready_go_s && allowin_s+1).
  - Combinational; no loop through flush inputs.
- Handoff: to_next_s = valid_s && ready_go_s.
- Load enables (stage s = ID..WB):
  - load_s = allowin_s && to_next_s-1 && !flush_s.
  - WB has no flush input.
  - Loading the downstream register only on load_s is the implementation rule.
- Valid update, each clock edge, priority order:
  1. flush_s: valid_s <= 0.
  2. Else if allowin_s: valid_s <= to_next_s-1.
  3. Else: hold.
- Bubble on ID stall:
  - When id_write_en = 0, to_next_ID = 0, so EX receives 0 if EX allows in.
  - ID holds its instruction while valid.
- IF fill:
  - if_load = inst_resp_valid && !resp_discard && if_allowin && !if_flush.
  - if_valid <= 1 on if_load.
  - if_valid <= 0 when IF hands off without a new load.
- Fetch request:
  - inst_req_valid = (outstanding < MAX_OUTSTANDING) && if_allowin && !if_flush && resetn.
  - A request is accepted when inst_req_valid && inst_req_ready.
- outstanding counter:
  - +1 on accept, -1 on inst_resp_valid.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows. A response with outstanding = 0 is a protocol error; assert in simulation.
- Discard:
  - On if_flush, discard <= outstanding - (inst_resp_valid ? 1 : 0). The request gate is 0 that cycle, so no new accept.
  - resp_discard = inst_resp_valid && (discard != 0).
  - Each discarded response decrements discard.
  - A flush while discard != 0 reloads discard with the current formula; it does not add.
- Simultaneous events:
  - A flush of a stage overrides its own load in the same cycle.
  - A flush of stage s does not gate stage s+1's load from s. Hazard detection flushes all younger stages together.
- A stalled stage must hold valid and must not be loaded while ready_go = 0 downstream backpressure exists.

Test Plan:
- Reset release with inst_req_ready = 1 and responses after 1 cycle:
  - inst_req_valid rises first cycle.
  - An instruction reaches wb_valid = 1 on cycle 5 after the first response.
  - Valid bits march one stage per cycle.
- id_write_en = 0 for 2 cycles with full pipe:
  - id_valid held at 1 and ex_valid = 0 for 2 cycles (bubbles).
  - IF held; if_load = 0.
  - Resumes with no lost or duplicated instruction.
- ex_ready_go = 0 for 3 cycles:
  - ex/id/if valid all held.
  - mem_valid = 0 for 3 cycles.
  - inst_req_valid = 0 once IF is full.
- if_flush = id_flush = ex_flush = 1 with outstanding = 2 and no response that cycle:
  - Next cycle if/id/ex_valid = 0 and discard = 2.
  - The next two responses have resp_discard = 1 and if_load = 0.
  - The third response loads.
- Flush coinciding with a response:
  - discard = outstanding - 1.
  - The response in that cycle is not loaded.
- mem_flush and ex_load in the same cycle:
  - mem_valid = 0 next cycle.
  - ex_valid loads normally.
